gpu_wb_region_bridge: RTL and testbench
=======================================

// Module: gpu_wb_region_bridge
// PURPOSE
//  Parametrised Wishbone classic slave front end for the GPU register/memory space.
//  Replaces the fixed 4-way write-only decoder and the free-running 50MHz ack divider with:
//   - an N-region decoder;
//   - programmable wait states;
//   - read-back support with per-region read latency;
//   - a proper CYC/STB/ACK handshake.
//  Sits between the system Wishbone bus and the GPU controller, spirit memory, tile map and texture memory.
// PARAMETERS
//  ADDR_W       27  Wishbone address width.
//  DATA_W       32  data width; SEL width = DATA_W/8.
//  NUM_REGIONS  4   number of decoded target regions (1..16).
//  DEC_LO       12  low bit of the region field in wb_adr_i.
//  DEC_W        4   region field width; region = wb_adr_i[DEC_LO+DEC_W-1:DEC_LO].
//  WAIT_CYCLES  1   wait states between request latch and target strobe (0..15).
//  RD_LATENCY   1   cycles from o_rd_en to valid i_rd_data (1..7).
// PORTS
//  clk          in   1                    system clock; all logic on posedge.
//  reset        in   1                    asynchronous, active-high reset.
//  wb_cyc_i     in   1                    bus cycle.
//  wb_stb_i     in   1                    strobe.
//  wb_we_i      in   1                    1 = write, 0 = read.
//  wb_sel_i     in   DATA_W/8             byte selects.
//  wb_adr_i     in   ADDR_W               address.
//  wb_dat_i     in   DATA_W               write data.
//  wb_dat_o     out  DATA_W               read data; valid while wb_ack_o = 1.
//  wb_ack_o     out  1                    one-cycle acknowledge.
//  wb_err_o     out  1                    error response; only with GPU_WB_ERR_EN, else tied 0.
//  o_wr_en      out  NUM_REGIONS          one-hot write strobe, one cycle.
//  o_rd_en      out  NUM_REGIONS          one-hot read strobe, one cycle.
//  o_addr       out  ADDR_W               latched address.
//  o_wdata      out  DATA_W               latched write data.
//  o_sel        out  DATA_W/8             latched byte selects.
//  i_rd_data    in   NUM_REGIONS*DATA_W   region r read data at [r*DATA_W +: DATA_W].
//  o_busy       out  1                    high in every state except IDLE.
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; every output 0; counters 0. Reset mid-transfer drops the transfer; no ack/err.
//  FSM states: IDLE, WAIT, ISSUE, RDWAIT, ACK.
//  IDLE:
//   - req = wb_cyc_i & wb_stb_i. On req, latch adr/dat/sel/we and decode region.
//   - Go to WAIT if WAIT_CYCLES > 0, else ISSUE.
//  WAIT: count WAIT_CYCLES cycles, then go to ISSUE.
//  ISSUE (1 cycle):
//   - Mapped region (region < NUM_REGIONS): o_wr_en[region] = 1 for a write, o_rd_en[region] = 1 for a read.
//   - Write -> ACK. Read -> RDWAIT.
//  RDWAIT:
//   - RD_LATENCY cycles; at the edge ending the last one, capture i_rd_data slice into wb_dat_o.
//   - Then go to ACK.
//  ACK (1 cycle): wb_ack_o = 1 (or wb_err_o, see CONFIGURATION); next state IDLE; wb_dat_o cleared on leaving ACK.
//  Latency from the sampled request edge:
//   - write ack in cycle WAIT_CYCLES + 2;
//   - read ack in cycle WAIT_CYCLES + 2 + RD_LATENCY.
//  Back-to-back: STB still high in the IDLE cycle after ACK is treated as a new request. Minimum 1 idle cycle between transfers.
//  Abort: wb_cyc_i = 0 in WAIT suppresses the strobe and returns to IDLE with no ack. Once ISSUE has executed, the transfer completes but ack is masked if wb_cyc_i = 0.
//  Unmapped region (region >= NUM_REGIONS): no o_wr_en/o_rd_en; read data = 0.
//  Bus inputs are ignored outside IDLE; o_addr/o_wdata/o_sel stay stable from latch until the next latch.
// CONFIGURATION
//  GPU_WB_ERR_EN defined:
//   - unmapped access ends with wb_err_o = 1 for one cycle in ACK;
//   - wb_ack_o stays 0; wb_dat_o = 0.
//  GPU_WB_ERR_EN undefined:
//   - wb_err_o tied 0;
//   - unmapped writes dropped and acked normally; unmapped reads ack with 0.
// TESTING
//  1. Default params, write adr=0x0_1004 dat=0xDEADBEEF sel=0xF:
//     o_wr_en = 4'b0010 in cycle 2, o_addr = 0x1004; ack in cycle 3 only.
//  2. Read adr=0x0_3000, i_rd_data region 3 = 0x12345678, RD_LATENCY = 2:
//     o_rd_en = 4'b1000 once; ack in cycle 5 with wb_dat_o = 0x12345678.
//  3. WAIT_CYCLES = 0, two back-to-back writes with STB held:
//     acks at cycles 2 and 5; o_wr_en pulses at cycles 1 and 4.
//  4. wb_cyc_i dropped during WAIT (WAIT_CYCLES = 3): no o_wr_en, no ack, o_busy = 0 next cycle.
//  5. Read of region 7 (unmapped), NUM_REGIONS = 4:
//     with GPU_WB_ERR_EN: wb_err_o = 1, ack = 0; without it: ack = 1, dat = 0.
//  6. reset asserted in RDWAIT: all outputs 0 immediately; next request after deassert serviced normally.

Source files
------------

// File: rtl/gpu_wb_region_bridge.sv
// rtl/gpu_wb_region_bridge.sv - Wishbone classic slave bridge: N-region decode, wait states, read-back.
// Optional GPU_WB_ERR_EN: unmapped accesses end with wb_err_o instead of wb_ack_o.
module gpu_wb_region_bridge #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 32,
    parameter int NUM_REGIONS = 4,
    parameter int DEC_LO      = 12,
    parameter int DEC_W       = 4,
    parameter int WAIT_CYCLES = 1,
    parameter int RD_LATENCY  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_cyc_i,
    input  logic                          wb_stb_i,
    input  logic                          wb_we_i,
    input  logic [DATA_W/8-1:0]           wb_sel_i,
    input  logic [ADDR_W-1:0]             wb_adr_i,
    input  logic [DATA_W-1:0]             wb_dat_i,
    output logic [DATA_W-1:0]             wb_dat_o,
    output logic                          wb_ack_o,
    output logic                          wb_err_o,
    output logic [NUM_REGIONS-1:0]        o_wr_en,
    output logic [NUM_REGIONS-1:0]        o_rd_en,
    output logic [ADDR_W-1:0]             o_addr,
    output logic [DATA_W-1:0]             o_wdata,
    output logic [DATA_W/8-1:0]           o_sel,
    input  logic [NUM_REGIONS*DATA_W-1:0] i_rd_data,
    output logic                          o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_RDWAIT,
        S_ACK
    } state_t;

    localparam logic [3:0]       WAIT_LAST   = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [2:0]       RD_LAST     = 3'(RD_LATENCY - 1);
    localparam logic [DEC_W:0]   REGION_LIM  = (DEC_W+1)'(NUM_REGIONS);
    localparam logic [NUM_REGIONS-1:0] ONE_HOT_BASE = NUM_REGIONS'(1);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            wait_cnt;
    logic [2:0]            rd_cnt;
    logic                  we_q;
    logic [DEC_W-1:0]      region_q;
    logic                  mapped_q;
    logic                  req;
    logic [DEC_W-1:0]      region_in;
    logic                  mapped_in;
    logic                  wait_done;
    logic                  rd_done;
    logic [DATA_W-1:0]     rd_slice;
    logic [NUM_REGIONS-1:0] region_onehot;

    assign req       = wb_cyc_i & wb_stb_i;
    assign region_in = wb_adr_i[DEC_LO +: DEC_W];
    assign mapped_in = ({1'b0, region_in} < REGION_LIM);
    assign wait_done = (wait_cnt == WAIT_LAST);
    assign rd_done   = (rd_cnt == RD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ISSUE;
                end
            end
            S_WAIT: begin
                // Dropping the cycle before the strobe abandons the transfer silently.
                if (!wb_cyc_i) begin
                    state_nxt = S_IDLE;
                end else if (wait_done) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:  state_nxt = we_q ? S_ACK : S_RDWAIT;
            S_RDWAIT: begin
                if (rd_done) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_slice = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (region_q == DEC_W'(r)) begin
                rd_slice = i_rd_data[r*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            rd_cnt   <= '0;
            we_q     <= 1'b0;
            region_q <= '0;
            mapped_q <= 1'b0;
            o_addr   <= '0;
            o_wdata  <= '0;
            o_sel    <= '0;
            wb_dat_o <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                we_q     <= wb_we_i;
                region_q <= region_in;
                mapped_q <= mapped_in;
                o_addr   <= wb_adr_i;
                o_wdata  <= wb_dat_i;
                o_sel    <= wb_sel_i;
            end

            if (state == S_WAIT && wb_cyc_i && !wait_done) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end

            if (state == S_RDWAIT && !rd_done) begin
                rd_cnt <= rd_cnt + 3'd1;
            end else begin
                rd_cnt <= '0;
            end

            // Read data is captured on the last latency edge and held only through ACK.
            if (state == S_RDWAIT && rd_done) begin
                wb_dat_o <= mapped_q ? rd_slice : '0;
            end else if (state == S_ACK) begin
                wb_dat_o <= '0;
            end
        end
    end

    assign region_onehot = ONE_HOT_BASE << region_q;
    assign o_wr_en = (state == S_ISSUE && we_q && mapped_q)  ? region_onehot : '0;
    assign o_rd_en = (state == S_ISSUE && !we_q && mapped_q) ? region_onehot : '0;
    assign o_busy  = (state != S_IDLE);

`ifdef GPU_WB_ERR_EN
    assign wb_ack_o = (state == S_ACK) && wb_cyc_i && mapped_q;
    assign wb_err_o = (state == S_ACK) && wb_cyc_i && !mapped_q;
`else
    assign wb_ack_o = (state == S_ACK) && wb_cyc_i;
    assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_wb_region_bridge.sv
// tb/tb_gpu_wb_region_bridge.sv - directed vector bench for gpu_wb_region_bridge.
module tb_gpu_wb_region_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         cyc, stb, we;
    logic [3:0]   sel;
    logic [26:0]  adr;
    logic [31:0]  dat;
    logic [2:0]   en;
    logic [127:0] rd_data;

    logic [31:0] dat_o   [3];
    logic        ack     [3];
    logic        err     [3];
    logic        busy    [3];
    logic [3:0]  wr_en   [3];
    logic [3:0]  rd_en   [3];
    logic [26:0] addr_o  [3];
    logic [31:0] wdata_o [3];
    logic [3:0]  sel_o   [3];

    gpu_wb_region_bridge #(.WAIT_CYCLES(1), .RD_LATENCY(2)) u_a (
        .clk(clk), .reset(reset), .wb_cyc_i(cyc & en[0]), .wb_stb_i(stb & en[0]),
        .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
        .o_wr_en(wr_en[0]), .o_rd_en(rd_en[0]), .o_addr(addr_o[0]),
        .o_wdata(wdata_o[0]), .o_sel(sel_o[0]), .i_rd_data(rd_data), .o_busy(busy[0]));

    gpu_wb_region_bridge #(.WAIT_CYCLES(0), .RD_LATENCY(1)) u_b (
        .clk(clk), .reset(reset), .wb_cyc_i(cyc & en[1]), .wb_stb_i(stb & en[1]),
        .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
        .o_wr_en(wr_en[1]), .o_rd_en(rd_en[1]), .o_addr(addr_o[1]),
        .o_wdata(wdata_o[1]), .o_sel(sel_o[1]), .i_rd_data(rd_data), .o_busy(busy[1]));

    gpu_wb_region_bridge #(.WAIT_CYCLES(3), .RD_LATENCY(1)) u_c (
        .clk(clk), .reset(reset), .wb_cyc_i(cyc & en[2]), .wb_stb_i(stb & en[2]),
        .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_dat_o(dat_o[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]),
        .o_wr_en(wr_en[2]), .o_rd_en(rd_en[2]), .o_addr(addr_o[2]),
        .o_wdata(wdata_o[2]), .o_sel(sel_o[2]), .i_rd_data(rd_data), .o_busy(busy[2]));

    typedef struct {
        int          d;
        logic        w;
        logic [26:0] a;
        logic [31:0] wd;
        logic [3:0]  s;
        int          strobe_cyc;
        logic [3:0]  strobe;
        int          ack_cyc;
        logic        unm;
        logic [31:0] rdat;
    } vec_t;

    vec_t vt [11];

    int nvec = 0;
    int nerr = 0;
    int cur  = 0;

    int          r_ack, r_err, r_nack, r_nerr, r_sc, r_nstb;
    logic [3:0]  r_wr, r_rd, r_sel;
    logic [31:0] r_wdata;
    logic [26:0] r_addr;
    logic        busy_log [16];
    logic [31:0] dat_log  [16];

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (case %0d): got %0h, expected %0h", nm, cur, act, exp);
        end
    endtask

    task automatic xfer(input int d, input logic w, input logic [26:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input int drop_at, input int ncyc);
        en = 3'b001 << d;
        we = w; adr = a; dat = wd; sel = s;
        r_ack = -1; r_err = -1; r_nack = 0; r_nerr = 0; r_sc = -1; r_nstb = 0;
        r_wr = '0; r_rd = '0; r_sel = '0; r_wdata = '0; r_addr = '0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == drop_at || r_ack >= 0 || r_err >= 0) begin
                    cyc = 1'b0; stb = 1'b0;
                end
            end
            @(negedge clk);
            busy_log[c] = busy[d];
            dat_log[c]  = dat_o[d];
            if (ack[d]) begin
                r_nack++;
                if (r_ack < 0) r_ack = c;
            end
            if (err[d]) begin
                r_nerr++;
                if (r_err < 0) r_err = c;
            end
            if (wr_en[d] != 4'd0 || rd_en[d] != 4'd0) begin
                r_nstb++;
                if (r_sc < 0) begin
                    r_sc = c; r_wr = wr_en[d]; r_rd = rd_en[d];
                    r_wdata = wdata_o[d]; r_sel = sel_o[d];
                end
            end
            r_addr = addr_o[d];
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_ack, exp_err, e;
        int a1, a2, w1c, w2c, nstb2;
        logic [3:0] w1v, w2v;
        logic b3;

        vt[0]  = '{0, 1'b1, 27'h0001004, 32'hDEADBEEF, 4'hF,  2, 4'b0010, 3, 1'b0, 32'h0};
        vt[1]  = '{0, 1'b0, 27'h0003000, 32'h0,        4'hF,  2, 4'b1000, 5, 1'b0, 32'h12345678};
        vt[2]  = '{0, 1'b0, 27'h0000010, 32'h0,        4'hF,  2, 4'b0001, 5, 1'b0, 32'hA0A00000};
        vt[3]  = '{1, 1'b1, 27'h0002FFC, 32'h0BADF00D, 4'h3,  1, 4'b0100, 2, 1'b0, 32'h0};
        vt[4]  = '{1, 1'b0, 27'h0001000, 32'h0,        4'hF,  1, 4'b0010, 3, 1'b0, 32'hB1B10001};
        vt[5]  = '{2, 1'b1, 27'h0000000, 32'h11112222, 4'h8,  4, 4'b0001, 5, 1'b0, 32'h0};
        vt[6]  = '{2, 1'b0, 27'h0002000, 32'h0,        4'hF,  4, 4'b0100, 6, 1'b0, 32'hC2C20002};
        vt[7]  = '{0, 1'b0, 27'h0007000, 32'h0,        4'hF, -1, 4'b0000, 5, 1'b1, 32'h0};
        vt[8]  = '{1, 1'b1, 27'h0005008, 32'hFFFFFFFF, 4'hF, -1, 4'b0000, 2, 1'b1, 32'h0};
        vt[9]  = '{1, 1'b1, 27'h7FF1ABC, 32'h5A5A5A5A, 4'h5,  1, 4'b0010, 2, 1'b0, 32'h0};
        vt[10] = '{2, 1'b0, 27'h000F000, 32'h0,        4'hF, -1, 4'b0000, 6, 1'b1, 32'h0};

        rd_data = {32'h12345678, 32'hC2C20002, 32'hB1B10001, 32'hA0A00000};
        reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0; en = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            cur = 100 + d;
            chk("reset_busy", busy[d], 0);
            chk("reset_ack", ack[d], 0);
            chk("reset_addr", addr_o[d], 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            cur = i;
            xfer(vt[i].d, vt[i].w, vt[i].a, vt[i].wd, vt[i].s, -1, 10);
            exp_ack = vt[i].ack_cyc;
            exp_err = -1;
`ifdef GPU_WB_ERR_EN
            if (vt[i].unm) begin
                exp_err = exp_ack;
                exp_ack = -1;
            end
`endif
            chk("ack_cycle", r_ack, exp_ack);
            chk("err_cycle", r_err, exp_err);
            chk("responses", r_nack + r_nerr, 1);
            chk("strobe_cycle", r_sc, vt[i].strobe_cyc);
            chk("strobe_count", r_nstb, vt[i].unm ? 0 : 1);
            chk("strobe_value", vt[i].w ? r_wr : r_rd, vt[i].strobe);
            chk("strobe_other", vt[i].w ? r_rd : r_wr, 0);
            chk("o_addr", r_addr, vt[i].a);
            e = (r_ack > r_err) ? r_ack : r_err;
            if (e >= 0) begin
                chk("busy_after", busy_log[e+1], 0);
                if (vt[i].w) begin
                    if (!vt[i].unm) begin
                        chk("o_wdata", r_wdata, vt[i].wd);
                        chk("o_sel", r_sel, vt[i].s);
                    end
                end else begin
                    chk("rd_data", dat_log[e], vt[i].rdat);
                    chk("rd_data_clr", dat_log[e+1], 0);
                end
            end
        end

        // Back-to-back writes on the zero-wait instance with STB held through the idle cycle.
        cur = 200;
        en = 3'b010; we = 1'b1; adr = 27'h0000000; dat = 32'h1; sel = 4'hF;
        a1 = -1; a2 = -1; w1c = -1; w2c = -1; w1v = '0; w2v = '0; nstb2 = 0; b3 = 1'b1;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 3) begin adr = 27'h0003004; dat = 32'h2; end
                if (a2 >= 0) begin cyc = 1'b0; stb = 1'b0; end
            end
            @(negedge clk);
            if (c == 3) b3 = busy[1];
            if (ack[1]) begin
                if (a1 < 0) a1 = c; else if (a2 < 0) a2 = c;
            end
            if (wr_en[1] != 4'd0) begin
                nstb2++;
                if (w1c < 0) begin w1c = c; w1v = wr_en[1]; end
                else if (w2c < 0) begin w2c = c; w2v = wr_en[1]; end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("b2b_ack1", a1, 2);
        chk("b2b_ack2", a2, 5);
        chk("b2b_wr1_cycle", w1c, 1);
        chk("b2b_wr1", w1v, 4'b0001);
        chk("b2b_wr2_cycle", w2c, 4);
        chk("b2b_wr2", w2v, 4'b1000);
        chk("b2b_strobes", nstb2, 2);
        chk("b2b_idle_gap", b3, 0);

        // Cycle dropped during WAIT on the three-wait-state instance.
        cur = 201;
        xfer(2, 1'b1, 27'h0001000, 32'hCAFEF00D, 4'hF, 2, 10);
        chk("abort_strobes", r_nstb, 0);
        chk("abort_ack", r_nack + r_nerr, 0);
        chk("abort_busy_wait", busy_log[2], 1);
        chk("abort_busy_next", busy_log[3], 0);

        // Cycle dropped after ISSUE: the read completes but the ack is masked.
        cur = 202;
        xfer(0, 1'b0, 27'h0002000, 32'h0, 4'hF, 3, 10);
        chk("mask_rd_cycle", r_sc, 2);
        chk("mask_rd", r_rd, 4'b0100);
        chk("mask_ack", r_nack + r_nerr, 0);
        chk("mask_busy_ack", busy_log[5], 1);
        chk("mask_busy_after", busy_log[6], 0);

        // Reset while waiting for read data, then a normal read.
        cur = 203;
        en = 3'b001; we = 1'b0; adr = 27'h0001000; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_busy_before", busy[0], 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy[0], 0);
        chk("rst_mid_ack", ack[0] | err[0], 0);
        chk("rst_mid_strobes", {wr_en[0], rd_en[0]}, 0);
        chk("rst_mid_addr", addr_o[0], 0);
        chk("rst_mid_dat", dat_o[0], 0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cur = 204;
        xfer(0, 1'b0, 27'h0001000, 32'h0, 4'hF, -1, 10);
        chk("rst_after_ack", r_ack, 5);
        chk("rst_after_rd", r_rd, 4'b0010);
        if (r_ack >= 0) chk("rst_after_dat", dat_log[r_ack], 32'hB1B10001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
